// File: rtl/elevator_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scan_ctrl
// Purpose  : N-floor elevator controller with SCAN (collective) scheduling.
//            Separate cabin, hall-up and hall-down call queues. Handles
//            emergency stop, overload, door hold, door re-open, travel abort
//            and fault status.
// Ports    : CLOCK_50  - system clock
//            reset_n   - asynchronous active-low reset
//            cab_call  - cabin buttons (level or pulse)
//            hall_up   - hall up calls (top bit ignored)
//            hall_dn   - hall down calls (bit 0 ignored)
//            emergency - stop and freeze (level)
//            overload  - inhibits departure, freezes door timer (level)
//            door_hold - freezes door timer while open (level)
//            floor     - current floor index
//            door_open - door open indicator
//            mov_up    - travelling up
//            mov_dn    - travelling down
//            dir_up    - committed scan direction
//            pending   - union of all call queues
//            fault     - high while in emergency stop
// Revision : 1.0 - initial release
// ============================================================================
module elevator_scan_ctrl #(
  parameter int N_FLOORS   = 8,
  parameter int FW         = $clog2(N_FLOORS),
  parameter int MOVE_TICKS = 50000000,
  parameter int DOOR_TICKS = 100000000,
  parameter int TW         = 27
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [N_FLOORS-1:0] cab_call,
  input  logic [N_FLOORS-1:0] hall_up,
  input  logic [N_FLOORS-1:0] hall_dn,
  input  logic                emergency,
  input  logic                overload,
  input  logic                door_hold,
  output logic [FW-1:0]       floor,
  output logic                door_open,
  output logic                mov_up,
  output logic                mov_dn,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending,
  output logic                fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MOVE  = 2'd1,
    S_DOOR  = 2'd2,
    S_EMERG = 2'd3
  } state_t;

  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_TICKS - 1);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(N_FLOORS - 1);

  state_t              state, state_nx;
  logic [FW-1:0]       floor_nx;
  logic                dir_nx;
  logic [TW-1:0]       timer, timer_nx;
  logic [N_FLOORS-1:0] cab_q, up_q, dn_q;
  logic [N_FLOORS-1:0] cab_nx, up_nx, dn_nx;
  logic [N_FLOORS-1:0] up_in, dn_in, here, above, below, ahead, behind;
  logic                ahead_any, behind_any, serve, reopen;

  // Floor-relative masks and the call sets derived from them.
  always_comb begin
    up_in = hall_up;
    up_in[N_FLOORS-1] = 1'b0;   // no "up" from the top floor
    dn_in = hall_dn;
    dn_in[0] = 1'b0;            // no "down" from the bottom floor
    here  = '0;
    above = '0;
    below = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      here[i]  = (i == int'(floor));
      above[i] = (i >  int'(floor));
      below[i] = (i <  int'(floor));
    end
    ahead      = pending & (dir_up ? above : below);
    behind     = pending & (dir_up ? below : above);
    ahead_any  = |ahead;
    behind_any = |behind;
    // A waiting hall call against the scan direction is only taken here
    // when nothing remains ahead; otherwise it waits for the return sweep.
    serve  = (|(cab_q & here))
           | (dir_up ? |(up_q & here) : |(dn_q & here))
           | ((|((up_q | dn_q) & here)) & ~ahead_any);
    // Live press at the open door's floor, in the direction being served.
    reopen = (|(cab_call & here))
           | (dir_up ? |(up_in & here) : |(dn_in & here));
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_nx = state;
    floor_nx = floor;
    dir_nx   = dir_up;
    timer_nx = timer;
    cab_nx   = cab_q | cab_call;
    up_nx    = up_q  | up_in;
    dn_nx    = dn_q  | dn_in;

    if (state == S_EMERG) begin
      cab_nx = cab_q;
      up_nx  = up_q;
      dn_nx  = dn_q;
    end

    if (emergency) begin
      // Abort whatever is in progress; partial travel time is discarded.
      state_nx = S_EMERG;
      timer_nx = '0;
    end else begin
      case (state)
        S_IDLE: begin
          timer_nx = '0;
          if (serve) begin
            cab_nx = cab_nx & ~here;
            if (dir_up || !ahead_any) up_nx = up_nx & ~here;
            if (!dir_up || !ahead_any) dn_nx = dn_nx & ~here;
            state_nx = S_DOOR;
          end else if (ahead_any && !overload) begin
            state_nx = S_MOVE;
          end else if (!ahead_any && behind_any) begin
            // Only reverse once the current sweep is exhausted, so an
            // overloaded car does not flip direction every cycle.
            dir_nx = ~dir_up;
          end
        end
        S_MOVE: begin
          if (timer == MOVE_LAST) begin
            timer_nx = '0;
            state_nx = S_IDLE;
            if (dir_up && floor != TOP_FLOOR) floor_nx = floor + FW'(1);
            else if (!dir_up && floor != '0) floor_nx = floor - FW'(1);
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
        S_DOOR: begin
          // Calls that this open door already serves are absorbed.
          cab_nx = cab_q | (cab_call & ~here);
          if (dir_up) up_nx = up_q | (up_in & ~here);
          else        dn_nx = dn_q | (dn_in & ~here);
          if (reopen) begin
            timer_nx = '0;
          end else if (!(door_hold || overload)) begin
            if (timer == DOOR_LAST) begin
              timer_nx = '0;
              state_nx = S_IDLE;
            end else begin
              timer_nx = timer + TW'(1);
            end
          end
        end
        S_EMERG: begin
          timer_nx = '0;
          state_nx = S_IDLE;
        end
        default: begin
          state_nx = S_IDLE;
          timer_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      floor  <= '0;
      dir_up <= 1'b1;
      timer  <= '0;
      cab_q  <= '0;
      up_q   <= '0;
      dn_q   <= '0;
    end else begin
      state  <= state_nx;
      floor  <= floor_nx;
      dir_up <= dir_nx;
      timer  <= timer_nx;
      cab_q  <= cab_nx;
      up_q   <= up_nx;
      dn_q   <= dn_nx;
    end
  end

  assign pending   = cab_q | up_q | dn_q;
  assign door_open = (state == S_DOOR);
  assign mov_up    = (state == S_MOVE) &&  dir_up;
  assign mov_dn    = (state == S_MOVE) && !dir_up;
  assign fault     = (state == S_EMERG);

endmodule
`default_nettype wire

// File: tb/tb_elevator_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_elevator_scan_ctrl
// Purpose  : Self-checking bench for elevator_scan_ctrl (4 floors, 4-cycle
//            travel, 6-cycle door dwell). Directed scenarios followed by
//            random call batches compared against a floor-level SCAN model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_scan_ctrl;
  localparam int NF = 4;
  localparam int MT = 4;
  localparam int DT = 6;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic [3:0] cab_call = '0;
  logic [3:0] hall_up  = '0;
  logic [3:0] hall_dn  = '0;
  logic       emergency = 1'b0;
  logic       overload  = 1'b0;
  logic       door_hold = 1'b0;
  logic [1:0] floor;
  logic       door_open, mov_up, mov_dn, dir_up, fault;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;
  int stops[$];
  int exp_q[$];
  bit prev_door = 1'b0;
  int m_pos;
  bit m_dir;

  always #5 CLOCK_50 = ~CLOCK_50;

  elevator_scan_ctrl #(
    .N_FLOORS(NF), .FW(2), .MOVE_TICKS(MT), .DOOR_TICKS(DT), .TW(27)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .cab_call(cab_call), .hall_up(hall_up), .hall_dn(hall_dn),
    .emergency(emergency), .overload(overload), .door_hold(door_hold),
    .floor(floor), .door_open(door_open), .mov_up(mov_up), .mov_dn(mov_dn),
    .dir_up(dir_up), .pending(pending), .fault(fault)
  );

  // Record the floor of every door opening.
  always @(negedge CLOCK_50) begin
    if (door_open && !prev_door) stops.push_back(int'(floor));
    prev_door = door_open;
  end

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    cab_call = '0; hall_up = '0; hall_dn = '0;
    emergency = 1'b0; overload = 1'b0; door_hold = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    stops.delete();
  endtask

  task automatic pulse(input logic [3:0] c, input logic [3:0] u, input logic [3:0] d);
    cab_call = c; hall_up = u; hall_dn = d;
    tick;
    cab_call = '0; hall_up = '0; hall_dn = '0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pending == 4'd0 && !door_open && !mov_up && !mov_dn) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic wait_door(input int budget, output bit ok, output int movc);
    ok = 1'b0;
    movc = 0;
    for (int i = 0; i < budget; i++) begin
      if (door_open) begin
        ok = 1'b1;
        break;
      end
      if (mov_up || mov_dn) movc++;
      tick;
    end
  endtask

  task automatic door_samples(output int n);
    n = 0;
    while (door_open && n < 60) begin
      n++;
      tick;
    end
  endtask

  task automatic cmp_stops(input string tag);
    chk({tag, "_nstops"}, stops.size(), exp_q.size());
    foreach (exp_q[i])
      chk($sformatf("%s_stop%0d", tag, i), (i < stops.size()) ? stops[i] : -1, exp_q[i]);
  endtask

  // Floor-granular SCAN reference: walks the car one floor at a time over
  // a batch of calls and lists the floors where the door opens.
  task automatic model_scan(input logic [3:0] ci, input logic [3:0] ui, input logic [3:0] di);
    bit c[4], u[4], d[4];
    int p;
    bit dir, fwd, back, srv;
    for (int i = 0; i < 4; i++) begin
      c[i] = ci[i];
      u[i] = ui[i] && (i != 3);
      d[i] = di[i] && (i != 0);
    end
    exp_q.delete();
    p = m_pos;
    dir = m_dir;
    for (int g = 0; g < 64; g++) begin
      fwd = 0; back = 0;
      for (int i = 0; i < 4; i++)
        if ((c[i] || u[i] || d[i]) && i != p) begin
          if ((i > p) == dir) fwd = 1; else back = 1;
        end
      if (!(c[p] || u[p] || d[p]) && !fwd && !back) break;
      srv = c[p] || (dir ? u[p] : d[p]) || ((u[p] || d[p]) && !fwd);
      if (srv) begin
        exp_q.push_back(p);
        c[p] = 0;
        if (dir) u[p] = 0; else d[p] = 0;
        if (!fwd) begin u[p] = 0; d[p] = 0; end
      end else if (fwd) begin
        p = dir ? p + 1 : p - 1;
      end else begin
        dir = !dir;
      end
    end
    m_pos = p;
    m_dir = dir;
  endtask

  initial begin
    bit ok, held_ok;
    int n, mc;
    logic [3:0] rc, ru, rd;

    // Reset state
    do_reset;
    chk("rst_floor", floor, 0);
    chk("rst_door", door_open, 0);
    chk("rst_movup", mov_up, 0);
    chk("rst_movdn", mov_dn, 0);
    chk("rst_dir", dir_up, 1);
    chk("rst_pending", pending, 0);
    chk("rst_fault", fault, 0);

    // Single cabin call to the top floor
    pulse(4'b1000, 4'b0000, 4'b0000);
    chk("t2_latched", pending, 4'b1000);
    wait_door(200, ok, mc);
    chk("t2_timeout", ok, 1);
    chk("t2_move_cycles", mc, 3 * MT);
    chk("t2_floor", floor, 3);
    chk("t2_pending", pending, 0);
    door_samples(n);
    chk("t2_door_len", n, DT);

    // Pass floor 1 going up, stop at 2, reverse, stop at 1
    do_reset;
    pulse(4'b0100, 4'b0000, 4'b0010);
    wait_idle(300, ok);
    chk("t3_timeout", ok, 1);
    exp_q = '{2, 1};
    cmp_stops("t3");

    // Both hall calls at floor 1 served by one stop
    do_reset;
    pulse(4'b0000, 4'b0010, 4'b0010);
    wait_idle(300, ok);
    chk("t4_timeout", ok, 1);
    exp_q = '{1};
    cmp_stops("t4");
    chk("t4_floor", floor, 1);

    // Door hold freezes the dwell timer at k=2
    do_reset;
    pulse(4'b0001, 4'b0000, 4'b0000);
    wait_door(50, ok, mc);
    chk("t5_timeout", ok, 1);
    tick;
    tick;
    door_hold = 1'b1;
    held_ok = 1'b1;
    repeat (20) begin
      tick;
      if (!door_open) held_ok = 1'b0;
    end
    chk("t5_held_open", held_ok, 1);
    door_hold = 1'b0;
    n = 0;
    while (door_open && n < 60) begin
      tick;
      n++;
    end
    chk("t5_close_after", n, DT - 2);

    // Re-open by cabin press at the current floor when the timer is 4
    do_reset;
    pulse(4'b0001, 4'b0000, 4'b0000);
    wait_door(50, ok, mc);
    chk("t6_timeout", ok, 1);
    repeat (4) tick;
    pulse(4'b0001, 4'b0000, 4'b0000);
    door_samples(n);
    chk("t6_reopen_len", n, DT);
    repeat (3) tick;
    chk("t6_pending", pending, 0);
    chk("t6_nstops", stops.size(), 1);

    // Overload in idle inhibits departure
    do_reset;
    overload = 1'b1;
    pulse(4'b0100, 4'b0000, 4'b0000);
    mc = 0;
    repeat (30) begin
      tick;
      if (mov_up || mov_dn) mc++;
    end
    chk("t6b_no_move", mc, 0);
    chk("t6b_floor", floor, 0);
    chk("t6b_pending", pending, 4'b0100);
    overload = 1'b0;
    wait_door(100, ok, mc);
    chk("t6b_timeout", ok, 1);
    chk("t6b_floor_after", floor, 2);

    // Emergency at move timer 2, calls ignored, restart from timer 0
    do_reset;
    pulse(4'b1000, 4'b0000, 4'b0000);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mov_up) begin ok = 1'b1; break; end
      tick;
    end
    chk("t7_move_timeout", ok, 1);
    tick;
    tick;
    emergency = 1'b1;
    tick;
    chk("t7_fault", fault, 1);
    chk("t7_mov", {mov_up, mov_dn}, 0);
    chk("t7_door", door_open, 0);
    chk("t7_floor", floor, 0);
    pulse(4'b0010, 4'b0100, 4'b0000);
    tick;
    chk("t7_queue_held", pending, 4'b1000);
    chk("t7_fault_held", fault, 1);
    emergency = 1'b0;
    mc = 0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (mov_up) mc++;
      if (floor == 2'd1) begin ok = 1'b1; break; end
    end
    chk("t7_restart_timeout", ok, 1);
    chk("t7_restart_cycles", mc, MT);
    chk("t7_fault_clear", fault, 0);
    wait_idle(300, ok);
    chk("t7_idle_timeout", ok, 1);
    exp_q = '{3};
    cmp_stops("t7");

    // Asynchronous reset mid-travel
    do_reset;
    pulse(4'b1000, 4'b0000, 4'b0000);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (floor == 2'd1 && mov_up) begin ok = 1'b1; break; end
      tick;
    end
    chk("t8_travel_timeout", ok, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t8_floor", floor, 0);
    chk("t8_pending", pending, 0);
    chk("t8_mov", {mov_up, mov_dn}, 0);
    chk("t8_door", door_open, 0);
    chk("t8_dir", dir_up, 1);
    chk("t8_fault", fault, 0);

    // Random call batches against the SCAN model
    do_reset;
    m_pos = 0;
    m_dir = 1'b1;
    for (int b = 0; b < 25; b++) begin
      rc = 4'($urandom);
      ru = 4'($urandom);
      rd = 4'($urandom);
      model_scan(rc, ru, rd);
      stops.delete();
      pulse(rc, ru, rd);
      wait_idle(500, ok);
      chk($sformatf("rnd%0d_timeout", b), ok, 1);
      cmp_stops($sformatf("rnd%0d", b));
      chk($sformatf("rnd%0d_floor", b), floor, m_pos);
      chk($sformatf("rnd%0d_dir", b), dir_up, m_dir);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
